gf8_pow_ctrl: RTL



---
 rtl/gf8_pkg.sv | 25 ++
 rtl/gf8_mul.sv | 23 ++
 rtl/gf8_pow_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions: reduction constant, power-controller state type,
// and the MSB-index helper used by the GF8_POW_EARLY_EXIT_EN build of gf8_pow_ctrl.
package gf8_pkg;

  // Low byte of x^8+x^4+x^3+x+1; the x^8 term is implied by the shift-out bit.
  localparam logic [7:0] GF8_POLY = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_DONE
  } gf8_pow_state_t;

  // Index of the highest set bit; 0 when e is zero.
  function automatic logic [2:0] gf8_msb_idx(input logic [7:0] e);
    logic [2:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) m = 3'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/gf8_mul.sv
// Combinational GF(2^8) multiplier, shift-and-add with reduction by GF8_POLY.
module gf8_mul
  import gf8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF8_POLY : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/gf8_pow_ctrl.sv
// Sequential r = a^e in GF(2^8) by left-to-right square-and-multiply on one shared
// multiplier. Define GF8_POW_EARLY_EXIT_EN to skip leading-zero exponent squarings.
module gf8_pow_ctrl
  import gf8_pkg::*;
#(
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [EXP_W-1:0] in_e,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_r,
  output logic             out_zero_err
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  gf8_pow_state_t   state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [7:0]       r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_r_q, out_r_d;
  logic             out_zero_err_q, out_zero_err_d;

  logic [EXP_W-1:0] eff_e;
  logic [IDX_W-1:0] idx_start;
  logic [7:0]       mul_b;
  logic [7:0]       mul_p;

  assign mul_b = (state_q == S_MUL) ? a_q : r_q;

  gf8_mul u_mul (
    .a (r_q),
    .b (mul_b),
    .p (mul_p)
  );

  assign eff_e = in_inv ? EXP_W'(8'hFE) : in_e;

`ifdef GF8_POW_EARLY_EXIT_EN
  logic [7:0] e_ext;
  always_comb begin
    e_ext = '0;
    e_ext[EXP_W-1:0] = eff_e;
    idx_start = IDX_W'(gf8_msb_idx(e_ext));
  end
`else
  assign idx_start = IDX_W'(EXP_W - 1);
`endif

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    e_d            = e_q;
    r_d            = r_q;
    idx_d          = idx_q;
    err_d          = err_q;
    out_valid_d    = out_valid_q;
    out_r_d        = out_r_q;
    out_zero_err_d = out_zero_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          e_d     = eff_e;
          err_d   = in_inv && (in_a == 8'h00);
          r_d     = 8'h01;
          idx_d   = idx_start;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        r_d = mul_p;
        if (e_q[idx_q]) begin
          state_d = S_MUL;
        end else if (idx_q == '0) begin
          state_d        = S_DONE;
          out_valid_d    = 1'b1;
          out_r_d        = err_q ? 8'h00 : mul_p;
          out_zero_err_d = err_q;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_MUL: begin
        r_d = mul_p;
        if (idx_q == '0) begin
          state_d        = S_DONE;
          out_valid_d    = 1'b1;
          out_r_d        = err_q ? 8'h00 : mul_p;
          out_zero_err_d = err_q;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_SQR;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d        = S_IDLE;
          out_valid_d    = 1'b0;
          out_zero_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers load on DONE entry so out_* never see a combinational path from in_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      e_q            <= '0;
      r_q            <= 8'h01;
      idx_q          <= '0;
      err_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_r_q        <= '0;
      out_zero_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      e_q            <= e_d;
      r_q            <= r_d;
      idx_q          <= idx_d;
      err_q          <= err_d;
      out_valid_q    <= out_valid_d;
      out_r_q        <= out_r_d;
      out_zero_err_q <= out_zero_err_d;
    end
  end

  assign in_ready     = rst_n && (state_q == S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_r        = out_r_q;
  assign out_zero_err = out_zero_err_q;

endmodule
